// File: rtl/nsa_pkg.sv
// nsa_pkg: shared state encoding and slice width for the nibble-serial adder
package nsa_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

// File: rtl/add4_slice.sv
// add4_slice: combinational 4-bit ripple-carry adder exposing every bit's carry-out
module add4_slice
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] s,
  output logic [NIBBLE_W-1:0] c_out
);
  logic [NIBBLE_W:0] w_c;
  assign w_c[0] = c_in;
  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]       = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end
  assign c_out = w_c[NIBBLE_W:1];
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add computed one nibble per cycle through a single 4-bit slice
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);
  localparam int CW = $clog2(NIB);
  state_t              r_state, w_next;
  logic [WIDTH-1:0]    r_a_sh, r_b_sh, r_s_sh, w_s_next;
  logic [CW-1:0]       r_cnt;
  logic                r_carry, w_last, w_accept;
  logic [NIBBLE_W-1:0] w_sum, w_c;

  add4_slice u_slice (
    .a    (r_a_sh[NIBBLE_W-1:0]),
    .b    (r_b_sh[NIBBLE_W-1:0]),
    .c_in (r_carry),
    .s    (w_sum),
    .c_out(w_c)
  );

  assign w_last   = r_cnt == CW'(NIB - 1);
  assign w_accept = start && r_state != ST_RUN;
  assign w_s_next = {w_sum, r_s_sh[WIDTH-1:NIBBLE_W]};

  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;

  always_comb
    w_next = r_state == ST_RUN ? (w_last ? ST_DONE : ST_RUN) : (start ? ST_RUN : ST_IDLE);

  always_comb begin
    busy = r_state == ST_RUN;
    done = r_state == ST_DONE;
  end

  // ovf is the carry into the sign bit XOR the carry out of it, taken from the top nibble
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      s       <= '0;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_carry <= c_in;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_a_sh  <= r_a_sh >> NIBBLE_W;
      r_b_sh  <= r_b_sh >> NIBBLE_W;
      r_s_sh  <= w_s_next;
      r_carry <= w_c[3];
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        s     <= w_s_next;
        c_out <= w_c[3];
        ovf   <= w_c[3] ^ w_c[2];
      end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and random checks of 16- and 8-bit instances against a latency/arithmetic model
module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st   [2] = '{1'b0, 1'b0};
  logic [15:0] a_in [2] = '{16'h0, 16'h0};
  logic [15:0] b_in [2] = '{16'h0, 16'h0};
  logic        ci   [2] = '{1'b0, 1'b0};
  logic        d_busy [2], d_done [2], d_c [2], d_v [2];
  logic [15:0] d_s [2];
  logic [7:0]  s8;
  int errors = 0, checks = 0;

  int          m_left [2] = '{0, 0};
  logic        m_done [2] = '{1'b0, 1'b0};
  logic [15:0] m_s    [2] = '{16'h0, 16'h0};
  logic        m_c    [2] = '{1'b0, 1'b0};
  logic        m_v    [2] = '{1'b0, 1'b0};
  logic [17:0] p_res  [2] = '{18'h0, 18'h0};

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(rst), .start(st[0]), .a(a_in[0]), .b(b_in[0]), .c_in(ci[0]),
    .busy(d_busy[0]), .done(d_done[0]), .s(d_s[0]), .c_out(d_c[0]), .ovf(d_v[0])
  );
  nibble_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst), .start(st[1]), .a(a_in[1][7:0]), .b(b_in[1][7:0]), .c_in(ci[1]),
    .busy(d_busy[1]), .done(d_done[1]), .s(s8), .c_out(d_c[1]), .ovf(d_v[1])
  );
  assign d_s[1] = {8'h00, s8};

  // returns {ovf, carry, sum} of a w-bit add
  function automatic logic [17:0] ref_add(input int w, input logic [15:0] a, input logic [15:0] b, input logic c);
    int msk, full, sa, sb, ss;
    msk  = (1 << w) - 1;
    full = (int'(a) & msk) + (int'(b) & msk) + int'(c);
    sa   = (int'(a) >> (w - 1)) & 1;
    sb   = (int'(b) >> (w - 1)) & 1;
    ss   = (full >> (w - 1)) & 1;
    return {1'(sa == sb && ss != sa), 1'((full >> w) & 1), 16'(full & msk)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst)
    for (int k = 0; k < 2; k++)
      if (rst) begin
        m_left[k] = 0; m_done[k] = 1'b0; m_s[k] = '0; m_c[k] = 1'b0; m_v[k] = 1'b0;
      end else if (m_left[k] > 0) begin
        m_left[k]--;
        m_done[k] = m_left[k] == 0;
        if (m_done[k]) {m_v[k], m_c[k], m_s[k]} = p_res[k];
      end else begin
        m_done[k] = 1'b0;
        if (st[k]) begin
          p_res[k]  = ref_add(k ? 8 : 16, a_in[k], b_in[k], ci[k]);
          m_left[k] = k ? 2 : 4;
        end
      end

  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      chk(k ? "busy8" : "busy16", 32'(d_busy[k]), 32'(m_left[k] > 0));
      chk(k ? "done8" : "done16", 32'(d_done[k]), 32'(m_done[k]));
      chk(k ? "s8" : "s16", 32'(d_s[k]), 32'(m_s[k]));
      chk(k ? "cout8" : "cout16", 32'(d_c[k]), 32'(m_c[k]));
      chk(k ? "ovf8" : "ovf16", 32'(d_v[k]), 32'(m_v[k]));
    end

  task automatic op(input int k, input logic [15:0] av, input logic [15:0] bv, input logic cv);
    int n, nb;
    logic got;
    @(posedge clk); #2;
    st[k] = 1'b1; a_in[k] = av; b_in[k] = bv; ci[k] = cv;
    @(posedge clk); #2;
    st[k] = 1'b0;
    n = 0; nb = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (d_busy[k]) nb++;
      got = d_done[k];
    end
    chk("latency", 32'(n), k ? 32'd3 : 32'd5);
    chk("busy_cycles", 32'(nb), k ? 32'd2 : 32'd4);
  endtask

  initial begin
    int n, nd;
    logic got;
    repeat (3) @(negedge clk);
    chk("rst_s", 32'(d_s[0]), 32'h0);
    chk("rst_busy", 32'(d_busy[0]), 32'h0);
    rst = 1'b0;

    op(0, 16'h1234, 16'h4321, 1'b0);
    chk("t1_s", 32'(d_s[0]), 32'h5555); chk("t1_c", 32'(d_c[0]), 0); chk("t1_v", 32'(d_v[0]), 0);
    op(0, 16'hFFFF, 16'h0001, 1'b0);
    chk("t2_s", 32'(d_s[0]), 32'h0); chk("t2_c", 32'(d_c[0]), 1); chk("t2_v", 32'(d_v[0]), 0);
    op(0, 16'h7FFF, 16'h0001, 1'b0);
    chk("t3_s", 32'(d_s[0]), 32'h8000); chk("t3_c", 32'(d_c[0]), 0); chk("t3_v", 32'(d_v[0]), 1);
    op(0, 16'h0000, 16'h0000, 1'b1);
    chk("t4_s", 32'(d_s[0]), 32'h0001);
    op(1, 16'h00FF, 16'h0001, 1'b0);
    chk("t5_s8", 32'(d_s[1]), 32'h0); chk("t5_c8", 32'(d_c[1]), 1);
    op(1, 16'h007F, 16'h0001, 1'b0);
    chk("t6_s8", 32'(d_s[1]), 32'h80); chk("t6_v8", 32'(d_v[1]), 1);

    @(posedge clk); #2;
    st[0] = 1'b1; a_in[0] = 16'h00FF; b_in[0] = 16'h0F0F; ci[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n = 0; got = 1'b0;
      while (!got && n < 12) begin
        @(negedge clk);
        n++;
        if (n == 2) a_in[0] = 16'h1111;
        if (n == 4) a_in[0] = 16'h00FF;
        got = d_done[0];
      end
      chk("b2b_s", 32'(d_s[0]), 32'h100E);
      if (i > 0) chk("b2b_gap", 32'(n), 32'd5);
    end
    st[0] = 1'b0;

    @(posedge clk); #2;
    st[0] = 1'b1; a_in[0] = 16'h1111; b_in[0] = 16'h2222; ci[0] = 1'b0;
    @(posedge clk); #2;
    st[0] = 1'b0;
    nd = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 2) begin st[0] = 1'b1; a_in[0] = 16'hAAAA; b_in[0] = 16'h5555; end
      if (i == 3) st[0] = 1'b0;
      if (d_done[0]) nd++;
    end
    chk("ign_dones", 32'(nd), 32'd1);
    chk("ign_s", 32'(d_s[0]), 32'h3333);

    @(posedge clk); #2;
    st[0] = 1'b1; a_in[0] = 16'h1234; b_in[0] = 16'h1111;
    @(posedge clk); #2;
    st[0] = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_s", 32'(d_s[0]), 32'h0);
    chk("arst_busy", 32'(d_busy[0]), 32'h0);
    chk("arst_done", 32'(d_done[0]), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (d_done[0]) nd++;
    end
    chk("arst_nodone", 32'(nd), 32'd0);
    op(0, 16'h8000, 16'h8000, 1'b0);
    chk("t7_s", 32'(d_s[0]), 32'h0); chk("t7_c", 32'(d_c[0]), 1); chk("t7_v", 32'(d_v[0]), 1);

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 1000; i++)
        op(k, 16'($urandom), 16'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
